// File: rtl/comb_decimator_pkg.sv
// Shared types and helpers for the decimating comb stage.
// Holds the default sample type, the sample range limits and the phase-counter width helper.
package comb_decimator_types;

  // Default sample width, matching the upstream integrator.
  localparam int SAMPLE_W = 10;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = sample_t'(511);
  localparam sample_t SAMPLE_MIN = sample_t'(-512);

  // The phase counter needs clog2(n) bits. For n of 1 or 2 that gives 0 or 1,
  // so a minimum of 1 bit is enforced to keep the vector legal.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comb_decimator_delay_line.sv
// comb_delay_line: DEPTH-deep shift register of signed samples.
// It has a shift enable and an async active-low clear. The oldest entry is presented on tap_last.
module comb_delay_line
  import comb_decimator_types::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 1
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic                     shift_en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] tap_last
);

  logic signed [DATA_W-1:0] taps [DEPTH];

  // Shift a new sample in on each enabled edge; reset clears all entries to zero.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign tap_last = taps[DEPTH-1];

endmodule

// File: rtl/comb_decimator.sv
// comb_decimator: decimating comb (differentiator) half of a CIC chain.
// It keeps every DECIM-th valid sample and outputs that sample minus the sample kept DIFF_DELAY decimated periods earlier.
// Each result comes with a one-cycle out_valid strobe.
// Optional build macro COMB_SATURATE_EN: when it is defined, the subtraction is clamped to the sample range.
// When it is undefined, the subtraction wraps modulo 2^DATA_W, which lets integrator overflow cancel.
module comb_decimator
  import comb_decimator_types::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int DECIM      = 4,
  parameter int DIFF_DELAY = 1
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid
);

  localparam int               CNT_W    = cnt_width(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0]         cnt;
  logic                     capture;
  logic signed [DATA_W-1:0] prev;
  logic signed [DATA_W-1:0] diff;

  assign capture = in_valid && (cnt == CNT_LAST);

  // Phase counter: advances on valid samples only and wraps after DECIM of them.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) cnt <= '0;
    else if (in_valid)    cnt <= capture ? '0 : cnt + 1'b1;
  end

  comb_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (DIFF_DELAY)
  ) u_delay (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .shift_en        (capture),
    .din             (in_data),
    .tap_last        (prev)
  );

`ifdef COMB_SATURATE_EN
  localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0] wide;

  assign wide = {in_data[DATA_W-1], in_data} - {prev[DATA_W-1], prev};

  // Clamp the one-bit-wider difference back into the sample range.
  always_comb begin
    diff = wide[DATA_W-1:0];
    if (wide > SAT_MAX)      diff = SAT_MAX[DATA_W-1:0];
    else if (wide < SAT_MIN) diff = SAT_MIN[DATA_W-1:0];
  end
`else
  assign diff = in_data - prev;
`endif

  // Register the comb result and raise the strobe one cycle after each capture.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= capture;
      if (capture) out_data <= diff;
    end
  end

endmodule

// File: tb/tb_comb_decimator.sv
// Self-checking bench for comb_decimator.
// Three instances share one input stream: (DECIM=4, DD=1), (DECIM=4, DD=2) and (DECIM=1, DD=1).
// Each instance is compared every cycle against a sample-counting reference model.
module tb_comb_decimator;

  localparam int N = 3;
  localparam int DECIM_C [N] = '{4, 4, 1};
  localparam int DD_C    [N] = '{1, 2, 1};

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [9:0] in_data;
  logic              in_valid;
  logic signed [9:0] od [N];
  logic              ov [N];

  int   checks = 0;
  int   errors = 0;

  // reference model state: valid count since reset, last two kept samples, expected outputs
  int   vcount [N];
  int   k1 [N];
  int   k2 [N];
  int   exp_data [N];
  logic exp_valid [N];

  always #5 clk = ~clk;

  comb_decimator #(.DATA_W(10), .DECIM(4), .DIFF_DELAY(1)) dut_a (
    .system1000(clk), .system1000_rstn(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[0]), .out_valid(ov[0]));
  comb_decimator #(.DATA_W(10), .DECIM(4), .DIFF_DELAY(2)) dut_b (
    .system1000(clk), .system1000_rstn(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[1]), .out_valid(ov[1]));
  comb_decimator #(.DATA_W(10), .DECIM(1), .DIFF_DELAY(1)) dut_c (
    .system1000(clk), .system1000_rstn(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(od[2]), .out_valid(ov[2]));

  function automatic int ref_sub(input int a, input int b);
    int d;
    d = a - b;
`ifdef COMB_SATURATE_EN
    if (d > 511)  d = 511;
    if (d < -512) d = -512;
`else
    d = d & 1023;
    if (d >= 512) d = d - 1024;
`endif
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      vcount[i] = 0; k1[i] = 0; k2[i] = 0; exp_data[i] = 0; exp_valid[i] = 1'b0;
    end
  endtask

  // One clock edge: the model consumes the inputs present at the edge. The outputs settle 1 ns later.
  task automatic tick();
    int x;
    @(posedge clk);
    x = int'(in_data);
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        exp_valid[i] = 1'b0;
        if (in_valid) begin
          vcount[i]++;
          if (vcount[i] % DECIM_C[i] == 0) begin
            exp_data[i]  = ref_sub(x, (DD_C[i] == 1) ? k1[i] : k2[i]);
            k2[i]        = k1[i];
            k1[i]        = x;
            exp_valid[i] = 1'b1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || od[i] !== 10'sd0) begin
        errors++;
        $display("FAIL reset_state inst%0d: valid=%b data=%0d, want 0/0", i, ov[i], od[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_ramp();
    int s0 [$];
    int t0 [$];
    int s1 [$];
    int want0 [3] = '{9, 12, 12};
    int want1 [4] = '{9, 21, 24, 24};
    do_reset();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 10'(3 * k);
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ov[i] !== exp_valid[i] || int'(od[i]) !== exp_data[i]) begin
          errors++;
          $display("FAIL ramp inst%0d k=%0d: valid=%b data=%0d, want %b/%0d", i, k, ov[i], od[i], exp_valid[i], exp_data[i]);
        end
      end
      if (ov[0]) begin s0.push_back(int'(od[0])); t0.push_back(k); end
      if (ov[1]) s1.push_back(int'(od[1]));
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (s0[j] !== want0[j] || t0[j] !== 4 * j + 3) begin
        errors++;
        $display("FAIL ramp_dd1 #%0d: got %0d at cycle %0d, want %0d at cycle %0d", j, s0[j], t0[j], want0[j], 4 * j + 3);
      end
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (s1[j] !== want1[j]) begin
        errors++;
        $display("FAIL ramp_dd2 #%0d: got %0d, want %0d", j, s1[j], want1[j]);
      end
    end
  endtask

  task automatic test_wrap();
    int s0 [$];
    int w1;
`ifdef COMB_SATURATE_EN
    w1 = 511;
`else
    w1 = -24;
`endif
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = (k < 4) ? -10'sd500 : 10'sd500;
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ov[i] !== exp_valid[i] || int'(od[i]) !== exp_data[i]) begin
          errors++;
          $display("FAIL wrap inst%0d k=%0d: valid=%b data=%0d, want %b/%0d", i, k, ov[i], od[i], exp_valid[i], exp_data[i]);
        end
      end
      if (ov[0]) s0.push_back(int'(od[0]));
    end
    checks++;
    if (s0.size() != 2 || s0[0] !== -500 || s0[1] !== w1) begin
      errors++;
      $display("FAIL wrap_seq: got %0d strobes first=%0d second=%0d, want 2 strobes -500 then %0d",
               s0.size(), (s0.size() > 0) ? s0[0] : 0, (s0.size() > 1) ? s0[1] : 0, w1);
    end
  endtask

  task automatic test_gaps();
    int s0 [$];
    int t0 [$];
    do_reset();
    for (int c = 0; c < 24; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = 10'(3 * (c / 2));
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ov[i] !== exp_valid[i] || int'(od[i]) !== exp_data[i]) begin
          errors++;
          $display("FAIL gaps inst%0d c=%0d: valid=%b data=%0d, want %b/%0d", i, c, ov[i], od[i], exp_valid[i], exp_data[i]);
        end
      end
      if (ov[0]) begin s0.push_back(int'(od[0])); t0.push_back(c); end
    end
    checks++;
    if (s0.size() != 3 || s0[0] !== 9 || s0[1] !== 12 || s0[2] !== 12 || t0[1] - t0[0] != 8 || t0[2] - t0[1] != 8) begin
      errors++;
      $display("FAIL gaps_seq: got %0d strobes, want 9,12,12 spaced 8 cycles", s0.size());
    end
  endtask

  task automatic test_reset_mid();
    int last;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 10'(100 + k);
      tick();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || od[i] !== 10'sd0) begin
        errors++;
        $display("FAIL reset_mid_clear inst%0d: valid=%b data=%0d, want 0/0", i, ov[i], od[i]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 10'($urandom_range(0, 1023));
      last     = int'(in_data);
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ov[i] !== exp_valid[i] || int'(od[i]) !== exp_data[i]) begin
          errors++;
          $display("FAIL reset_mid inst%0d k=%0d: valid=%b data=%0d, want %b/%0d", i, k, ov[i], od[i], exp_valid[i], exp_data[i]);
        end
      end
    end
    checks++;
    if (ov[0] !== 1'b1 || int'(od[0]) !== last) begin
      errors++;
      $display("FAIL reset_mid_first: valid=%b data=%0d, want 1/%0d", ov[0], od[0], last);
    end
  endtask

  task automatic test_decim1();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 10'sd7;
      tick();
      checks++;
      if (ov[2] !== 1'b1 || int'(od[2]) !== ((k == 0) ? 7 : 0)) begin
        errors++;
        $display("FAIL decim1 k=%0d: valid=%b data=%0d, want 1/%0d", k, ov[2], od[2], (k == 0) ? 7 : 0);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 10'($urandom);
      tick();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (ov[i] !== exp_valid[i] || int'(od[i]) !== exp_data[i]) begin
          errors++;
          $display("FAIL random inst%0d c=%0d: valid=%b data=%0d, want %b/%0d", i, c, ov[i], od[i], exp_valid[i], exp_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_wrap();
    test_gaps();
    test_reset_mid();
    test_decim1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
